xadc_drp_arbiter: RTL and testbench

XADC_DRP_ARBITER -- requirements
Module: xadc_drp_arbiter

---
 rtl/xadc_drp_arbiter_if.sv | 47 ++++
 rtl/xadc_drp_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_xadc_drp_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_drp_arbiter_if.sv
// Signal bundle between the two DRP requesters, the arbiter and the XADC DRP port.
//
// Requester side : req0/1, we0/1, addr0/1, wdata0/1 in; gnt0/1, done0/1, rdata, err out.
// XADC side      : DADDR, DI, DEN, DWE out; DO, DRDY, BUSY in.
//
// modport master : the arbiter's view (it masters the DRP port and answers the requesters).
// modport slave  : the environment's view (both requesters plus the XADC primitive).
interface xadc_drp_arbiter_if;
  // Requester 0 (host config) and requester 1 (auto-readout).
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [6:0]  addr0;
  logic [6:0]  addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [15:0] rdata;
  logic        err;

  // XADC DRP port.
  logic [6:0]  DADDR;
  logic [15:0] DI;
  logic        DEN;
  logic        DWE;
  logic [15:0] DO;
  logic        DRDY;
  logic        BUSY;

  modport master (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  DO, DRDY, BUSY,
    output gnt0, gnt1, done0, done1, rdata, err,
    output DADDR, DI, DEN, DWE
  );

  modport slave (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output DO, DRDY, BUSY,
    input  gnt0, gnt1, done0, done1, rdata, err,
    input  DADDR, DI, DEN, DWE
  );
endinterface

// File: rtl/xadc_drp_arbiter.sv
// Two-requester arbiter in front of a single XADC DRP port.
//
// Exactly one DRP access is in flight at a time. Each access walks
// IDLE (grant) -> ISSUE (DEN pulse) -> WAIT (for DRDY or timeout) -> DONE (done pulse),
// so the shortest access takes four cycles. Ties between the two requesters alternate
// round-robin; writes are held off while the XADC reports BUSY, reads are not.
//
// Parameters:
//   TIMEOUT : number of WAIT cycles allowed before the access is aborted with err=1 (>= 1).
// Ports:
//   clk : rising-edge clock.
//   rst : asynchronous active-high reset; forces IDLE and zeroes every output.
//   bus : xadc_drp_arbiter_if.master -- requester handshakes, result and the DRP master port.
module xadc_drp_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst,
  xadc_drp_arbiter_if.master bus
);

  // Counter is at least 8 bits and always wide enough to hold TIMEOUT.
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic            win_q, win_d;     // port index of the access in flight
  logic            last_q, last_d;   // port index granted most recently
  logic            we_q, we_d;
  logic [6:0]      addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;     // WAIT cycles already spent without DRDY

  logic            elig0, elig1;
  logic            win_valid;
  logic            win_idx;
  logic [CntW-1:0] cnt_inc;
  logic            timeout_hit;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // A write must not be started while the XADC is busy; reads may go at any time.
  assign elig0     = bus.req0 & (~bus.we0 | ~bus.BUSY);
  assign elig1     = bus.req1 & (~bus.we1 | ~bus.BUSY);
  assign win_valid = elig0 | elig1;
  // On a tie the port that was not granted last goes first.
  assign win_idx   = (elig0 & elig1) ? ~last_q : elig1;

  // This WAIT cycle is the TIMEOUT-th one without DRDY.
  assign cnt_inc     = cnt_q + CntW'(1);
  assign timeout_hit = (cnt_inc == TimeoutVal);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (win_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      // DRDY wins over a coinciding timeout; both leave WAIT.
      StWait:  if (bus.DRDY || timeout_hit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (win_valid) begin
          win_d   = win_idx;
          last_d  = win_idx;
          we_d    = win_idx ? bus.we1    : bus.we0;
          addr_d  = win_idx ? bus.addr1  : bus.addr0;
          wdata_d = win_idx ? bus.wdata1 : bus.wdata0;
        end
      end
      StIssue: cnt_d = '0;
      StWait: begin
        if (bus.DRDY) begin
          // Writes complete without touching the last read value.
          if (!we_q) rdata_d = bus.DO;
          err_d = 1'b0;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= 1'b0;
      last_q  <= 1'b1;  // port 0 wins the first tie after reset
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.gnt0  = 1'b0;
    bus.gnt1  = 1'b0;
    bus.done0 = 1'b0;
    bus.done1 = 1'b0;
    bus.DEN   = 1'b0;
    bus.DWE   = 1'b0;
    bus.DADDR = '0;
    bus.DI    = '0;
    case (state_q)
      StIdle: begin
        // Grant is decoded from live requests; gate it so nothing leaks out while rst is high.
        bus.gnt0 = win_valid & ~win_idx & ~rst;
        bus.gnt1 = win_valid &  win_idx & ~rst;
      end
      StIssue: begin
        bus.DEN   = 1'b1;
        bus.DWE   = we_q;
        bus.DADDR = addr_q;
        bus.DI    = wdata_q;
      end
      StWait: begin
        bus.DADDR = addr_q;
        bus.DI    = wdata_q;
      end
      StDone: begin
        bus.done0 = ~win_q;
        bus.done1 =  win_q;
        bus.DADDR = addr_q;
        bus.DI    = wdata_q;
      end
      default: ;
    endcase
    bus.rdata = rdata_q;
    bus.err   = err_q;
  end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Bench for xadc_drp_arbiter: directed scenarios with literal expectations, plus a
// transaction-level reference model checked against the DUT on every falling edge.
module tb_xadc_drp_arbiter;
  localparam int unsigned Timeout = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xadc_drp_arbiter_if bus ();

  xadc_drp_arbiter #(
    .TIMEOUT(Timeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // DRP responder: answers each DEN after rsp_delay cycles (0 = never answers).
  int          rsp_delay  = 1;
  logic [15:0] rsp_data   = '0;
  logic        rsp_drdy   = 1'b0;
  logic [15:0] rsp_do     = '0;
  logic        stray_drdy = 1'b0;
  logic [15:0] stray_do   = '0;

  assign bus.DRDY = rsp_drdy | stray_drdy;
  assign bus.DO   = rsp_drdy ? rsp_do : stray_do;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.gnt0;
      1:       return bus.gnt1;
      2:       return bus.done0;
      3:       return bus.done1;
      default: return bus.DEN;
    endcase
  endfunction

  // Waits (bounded) for a pulse: 0 gnt0, 1 gnt1, 2 done0, 3 done1, 4 DEN.
  task automatic wait_sig(input string name, input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig(which)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      $display("FAIL %s: no pulse within %0d cycles (cycle %0d)", name, budget, cyc);
    end
  endtask

  initial begin : responder
    forever begin
      @(negedge clk);
      if (bus.DEN && !rst && rsp_delay > 0) begin
        @(posedge clk);
        repeat (rsp_delay - 1) @(posedge clk);
        #1;
        rsp_do   = rsp_data;
        rsp_drdy = 1'b1;
        @(posedge clk);
        #1;
        rsp_drdy = 1'b0;
      end
    end
  end

  // Reference model: an access is tracked by its age in cycles since the grant.
  // Age 1 is the DEN cycle, ages >= 2 wait for DRDY (wait cycle n = age-1), and the
  // cycle after completion carries done. Result registers change with completion.
  initial begin : compare
    bit          m_act, m_we, m_done_next, elig0, elig1;
    int          m_age, m_win, m_last, w;
    logic [6:0]  m_addr, e_addr;
    logic [15:0] m_wdata, m_rdata, e_di;
    logic        m_err;
    logic [5:0]  e_ctrl;
    m_act = 0; m_we = 0; m_done_next = 0; m_age = 0; m_win = 0; m_last = 1;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs", 64'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.DEN, bus.DWE,
                                    bus.DADDR, bus.DI, bus.rdata, bus.err}), 64'd0);
        m_act = 0; m_done_next = 0; m_age = 0; m_last = 1; m_rdata = '0; m_err = 1'b0;
      end else begin
        e_ctrl = '0;
        e_addr = '0;
        e_di   = '0;
        w      = -1;
        elig0  = bus.req0 && (!bus.we0 || !bus.BUSY);
        elig1  = bus.req1 && (!bus.we1 || !bus.BUSY);
        if (!m_act) begin
          if (elig0 || elig1) begin
            w = (elig0 && elig1) ? (1 - m_last) : (elig0 ? 0 : 1);
            e_ctrl[5-w] = 1'b1;
          end
        end else begin
          e_addr = m_addr;
          e_di   = m_wdata;
          if (m_age == 1) begin
            e_ctrl[1] = 1'b1;
            e_ctrl[0] = m_we;
          end else if (m_done_next) begin
            e_ctrl[3-m_win] = 1'b1;
          end
        end
        check("ctrl{gnt0,gnt1,done0,done1,den,dwe}",
              64'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.DEN, bus.DWE}), 64'(e_ctrl));
        check("drp{daddr,di}", 64'({bus.DADDR, bus.DI}), 64'({e_addr, e_di}));
        check("result{rdata,err}", 64'({bus.rdata, bus.err}), 64'({m_rdata, m_err}));
        // Advance to the next cycle.
        if (!m_act) begin
          if (w >= 0) begin
            m_act = 1; m_age = 1; m_win = w; m_last = w; m_done_next = 0;
            m_we    = (w == 1) ? bus.we1    : bus.we0;
            m_addr  = (w == 1) ? bus.addr1  : bus.addr0;
            m_wdata = (w == 1) ? bus.wdata1 : bus.wdata0;
          end
        end else if (m_age == 1) begin
          m_age = 2;
        end else if (m_done_next) begin
          m_act = 0;
        end else begin
          if (bus.DRDY) begin
            if (!m_we) m_rdata = bus.DO;
            m_err = 1'b0;
            m_done_next = 1;
          end else if (m_age - 1 == int'(Timeout)) begin
            m_rdata = '0;
            m_err = 1'b1;
            m_done_next = 1;
          end
          m_age++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "time limit reached");
  end

  int t_g, t_i, t_d, n;
  int glog[4];

  initial begin : main
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0; bus.BUSY = 0;
    for (int k = 0; k < 4; k++) glog[k] = -1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_state", 64'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.DEN, bus.DWE,
                              bus.DADDR, bus.DI, bus.rdata, bus.err}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single read from port 1, DRDY two cycles after DEN.
    rsp_delay = 2; rsp_data = 16'hABC0;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 7'h10; bus.wdata1 = 16'h0F0F;
    wait_sig("rd_gnt1", 1, 4, t_g);
    wait_sig("rd_den", 4, 4, t_i);
    check("rd_issue_latency", 64'(t_i - t_g), 64'd1);
    check("rd_issue_bus{daddr,dwe}", 64'({bus.DADDR, bus.DWE}), 64'({7'h10, 1'b0}));
    wait_sig("rd_done1", 3, 8, t_d);
    check("rd_done_latency", 64'(t_d - t_i), 64'd3);
    check("rd_result{rdata,err}", 64'({bus.rdata, bus.err}), 64'({16'hABC0, 1'b0}));
    tick();
    bus.req1 = 0;

    // Both ports requesting continuously: grants alternate starting with port 0.
    rsp_delay = 1; rsp_data = 16'h5A5A;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 7'h01;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 7'h02;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        check("rr_single_gnt", 64'(bus.gnt0 & bus.gnt1), 64'd0);
        glog[n] = bus.gnt1 ? 1 : 0;
        n++;
      end
    end
    tick();
    bus.req0 = 0; bus.req1 = 0;
    check("rr_grant_count", 64'(n), 64'd4);
    for (int k = 0; k < 4; k++) check("rr_order", 64'(glog[k]), 64'(k % 2));
    wait_sig("rr_last_done1", 3, 8, t_d);
    check("rr_rdata", 64'(bus.rdata), 64'h5A5A);
    tick();

    // Write held off by BUSY, then issued; req dropped right after the grant.
    rsp_data = 16'hDEAD;
    bus.BUSY = 1; bus.req0 = 1; bus.we0 = 1; bus.addr0 = 7'h41; bus.wdata0 = 16'h1234;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.gnt0) n++;
    end
    check("busy_no_gnt0", 64'(n), 64'd0);
    tick();
    bus.BUSY = 0;
    wait_sig("wr_gnt0", 0, 2, t_g);
    tick();
    bus.req0 = 0;
    @(negedge clk);
    check("wr_issue{den,dwe,daddr,di}", 64'({bus.DEN, bus.DWE, bus.DADDR, bus.DI}),
          64'({1'b1, 1'b1, 7'h41, 16'h1234}));
    wait_sig("wr_done0", 2, 8, t_d);
    check("wr_result{rdata,err}", 64'({bus.rdata, bus.err}), 64'({16'h5A5A, 1'b0}));
    tick();

    // DRDY while idle is ignored.
    stray_do = 16'h7777; stray_drdy = 1;
    tick();
    tick();
    stray_drdy = 0;
    @(negedge clk);
    check("stray_drdy_ignored", 64'({bus.rdata, bus.err}), 64'({16'h5A5A, 1'b0}));
    tick();

    // Timeout: no DRDY; 255 WAIT cycles follow ISSUE, done in the cycle after them.
    rsp_delay = 0;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 7'h22;
    wait_sig("to_gnt1", 1, 3, t_g);
    wait_sig("to_den", 4, 3, t_i);
    wait_sig("to_done1", 3, 300, t_d);
    check("to_latency", 64'(t_d - t_i), 64'(Timeout + 1));
    check("to_result{rdata,err}", 64'({bus.rdata, bus.err}), 64'({16'h0000, 1'b1}));
    tick();
    bus.req1 = 0;

    // DRDY in the very cycle the timeout would fire: normal completion.
    rsp_delay = Timeout; rsp_data = 16'h3C3C;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 7'h33;
    wait_sig("edge_gnt0", 0, 3, t_g);
    wait_sig("edge_den", 4, 3, t_i);
    wait_sig("edge_done0", 2, 300, t_d);
    check("edge_latency", 64'(t_d - t_i), 64'(Timeout + 1));
    check("edge_result{rdata,err}", 64'({bus.rdata, bus.err}), 64'({16'h3C3C, 1'b0}));
    tick();
    bus.req0 = 0;

    // DRDY one cycle too late lands in DONE and is ignored.
    rsp_delay = Timeout + 1; rsp_data = 16'h9999;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 7'h34;
    wait_sig("late_gnt0", 0, 3, t_g);
    wait_sig("late_done0", 2, 300, t_d);
    check("late_result{rdata,err}", 64'({bus.rdata, bus.err}), 64'({16'h0000, 1'b1}));
    tick();
    bus.req0 = 0;
    @(negedge clk);
    check("late_drdy_ignored", 64'({bus.rdata, bus.err}), 64'({16'h0000, 1'b1}));
    tick();

    // Reset in the middle of WAIT.
    rsp_delay = 0;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 7'h55;
    wait_sig("mid_gnt1", 1, 3, t_g);
    wait_sig("mid_den", 4, 3, t_i);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 7'h0A;
    #1;
    check("rst_mid_access", 64'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.DEN, bus.DWE,
                                 bus.DADDR, bus.DI, bus.rdata, bus.err}), 64'd0);
    rsp_delay = 1; rsp_data = 16'h1111;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tie{gnt0,gnt1}", 64'({bus.gnt0, bus.gnt1}), 64'({1'b1, 1'b0}));
    wait_sig("post_rst_done0", 2, 6, t_d);
    check("post_rst_result{rdata,err}", 64'({bus.rdata, bus.err}), 64'({16'h1111, 1'b0}));
    tick();
    bus.req0 = 0;
    wait_sig("post_rst_done1", 3, 10, t_d);
    tick();
    bus.req1 = 0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
